// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// Pure declarations, no logic; no latency.
// Not applicable: holds no state and applies no backpressure.
package lsu_pkg;

  // RV32I width/sign field values
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Store-size encodings as the data memory expects them
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'b00,
    FAULT_MISALIGNED = 2'b01,
    FAULT_ACCESS     = 2'b10,
    FAULT_ILLEGAL    = 2'b11
  } fault_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
  } lsu_state_e;

  // Number of bytes touched by an access of the given size code
  function automatic logic [2:0] access_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: access_bytes = 3'd1;
      SIZE_HALF: access_bytes = 3'd2;
      default:   access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the loaded byte/half/word from the low bytes and sign/zero extends it.
// Purely combinational, zero latency.
// No handshake; the caller samples the result when the read data is valid.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  // Memory returns bytes addr..addr+3, so the wanted data always sits at bit 0
  always_comb begin
    result_o = rdata_i;
    case (funct3_i)
      F3_LB:   result_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
      F3_LBU:  result_o = {24'd0, rdata_i[7:0]};
      F3_LH:   result_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
      F3_LHU:  result_o = {16'd0, rdata_i[15:0]};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, checks it, drives the memory port, returns a response.
// Latency from acceptance: store or fault response 2 cycles later, load response 3 cycles later.
// One request in flight; req_ready is low while busy and the response is held until rsp_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_is_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_base_i,
  input  logic [31:0] req_offset_i,
  input  logic [31:0] req_store_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_load_data_o,
  output logic        rsp_fault_o,
  output logic [1:0]  rsp_fault_cause_o,
  output logic [31:0] rsp_addr_o,
  output logic        mem_read_en_o,
  output logic        mem_write_en_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_store_size_o,
  output logic [31:0] mem_write_data_o,
  input  logic [31:0] mem_read_data_i
);

  lsu_state_e   state_q, state_d;
  logic         is_store_q;
  logic [2:0]   funct3_q;
  logic [31:0]  sdata_q;
  logic [31:0]  addr_q;
  logic [31:0]  load_data_q;
  logic         fault_q;
  fault_cause_e cause_q;

  fault_cause_e chk_cause;
  logic         legal;
  logic [2:0]   nbytes;
  logic [32:0]  last_byte;
  logic         issue_ok;
  logic [31:0]  aligned_data;

  lsu_load_align u_align (
    .funct3_i (funct3_q),
    .rdata_i  (mem_read_data_i),
    .result_o (aligned_data)
  );

  // Classify the registered request: illegal beats misaligned beats out-of-range
  always_comb begin
    nbytes    = access_bytes(funct3_q[1:0]);
    last_byte = {1'b0, addr_q} + {30'd0, nbytes} - 33'd1;
    if (is_store_q) legal = funct3_q inside {F3_SB, F3_SH, F3_SW};
    else            legal = funct3_q inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    chk_cause = FAULT_NONE;
    if (!legal)
      chk_cause = FAULT_ILLEGAL;
    else if ((funct3_q[1:0] == SIZE_HALF && addr_q[0]) ||
             (funct3_q[1:0] == SIZE_WORD && addr_q[1:0] != 2'b00))
      chk_cause = FAULT_MISALIGNED;
    else if (last_byte >= 33'(MEM_SIZE))
      chk_cause = FAULT_ACCESS;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    issue_ok    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        issue_ok = (chk_cause == FAULT_NONE);
        state_d  = (!is_store_q && issue_ok) ? ST_CAPTURE : ST_RESP;
      end
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port: live only in ISSUE for a clean request; reset kills an in-flight write
  always_comb begin
    mem_read_en_o    = 1'b0;
    mem_write_en_o   = 1'b0;
    mem_addr_o       = 32'd0;
    mem_store_size_o = SIZE_BYTE;
    mem_write_data_o = 32'd0;
    if (issue_ok && !reset) begin
      mem_addr_o       = addr_q;
      mem_store_size_o = funct3_q[1:0];
      if (is_store_q) begin
        mem_write_en_o   = 1'b1;
        mem_write_data_o = sdata_q;
      end else begin
        mem_read_en_o = 1'b1;
      end
    end
  end

  // Request capture and response registers; untouched in RESP so outputs stay stable
  always_ff @(posedge clk) begin
    if (reset) begin
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      sdata_q     <= 32'd0;
      addr_q      <= 32'd0;
      load_data_q <= 32'd0;
      fault_q     <= 1'b0;
      cause_q     <= FAULT_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            is_store_q <= req_is_store_i;
            funct3_q   <= req_funct3_i;
            sdata_q    <= req_store_data_i;
            addr_q     <= req_base_i + req_offset_i;
          end
        end
        ST_ISSUE: begin
          fault_q     <= (chk_cause != FAULT_NONE);
          cause_q     <= chk_cause;
          load_data_q <= 32'd0;
        end
        ST_CAPTURE: load_data_q <= aligned_data;
        default: ;
      endcase
    end
  end

  assign rsp_load_data_o   = load_data_q;
  assign rsp_fault_o       = fault_q;
  assign rsp_fault_cause_o = cause_q;
  assign rsp_addr_o        = addr_q;

endmodule
